cache_miss_fill_ctrl: RTL and testbench
=======================================

# cache_miss_fill_ctrl

Miss-fill controller between the instruction cache, the data cache and the multi-cycle main memory of the pipelined 16-bit CPU. On a cache miss it fetches the whole 16-byte block (8 words) from memory, streams each returning word into the requesting cache's data array, then writes the tag. It arbitrates between simultaneous I- and D-misses and drives the `i_fill_busy` / `d_fill_busy` stall signals that freeze the pipeline during a fill.

## Interface
Parameters:
- `WORDS_PER_BLK`, 8, words per cache block; a power of two, word = 16 bits, byte-addressed.
- `MEM_LAT`, 4, cycles from `mem_rd_en` to the matching `mem_data_valid`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; one clock, synchronous, active-low.
- `i_miss`  in  1  I-cache miss, level; held until its fill completes.
- `i_miss_addr`  in  16  I-cache miss byte address.
- `d_miss`  in  1  D-cache miss, level.
- `d_miss_addr`  in  16  D-cache miss byte address.
- `mem_rd_en`  out  1  memory read strobe, one word per cycle.
- `mem_addr`  out  16  memory read byte address.
- `mem_data_valid`  in  1  returned word valid.
- `mem_data_in`  in  16  returned word.
- `fill_sel`  out  1  target cache: 0 = I, 1 = D.
- `fill_data`  out  16  word to write into the target cache's data array.
- `fill_word_we`  out  1  data-array word write enable.
- `fill_word_idx`  out  log2(WORDS_PER_BLK)  word offset within the block.
- `fill_tag_we`  out  1  tag/valid write enable for the target cache's set.
- `fill_done`  out  1  one-cycle pulse when the block is complete.
- `i_fill_busy`  out  1  I-fill in progress.
- `d_fill_busy`  out  1  D-fill in progress.

## Operation
- States: IDLE, FILL, DONE, COOL.
- IDLE: if `d_miss`, latch `d_miss_addr`, set `fill_sel`=1 and go to FILL. Else if `i_miss`, latch `i_miss_addr`, set `fill_sel`=0 and go to FILL. D has strict priority. `mem_data_valid` is ignored.
- Block base = latched address with the low log2(WORDS_PER_BLK)+1 bits cleared.
- FILL issue: `issue_cnt` runs 0..WORDS_PER_BLK-1. Each cycle the block drives `mem_rd_en`=1 and `mem_addr`=base+2*issue_cnt. The counter stops after the last word.
- FILL receive: on each `mem_data_valid`, drive `fill_word_we`=1, `fill_data`=`mem_data_in` and `fill_word_idx`=`recv_cnt`, then increment `recv_cnt`. The block does not count or check latency; it relies only on in-order return.
- On the cycle the last word is received (`recv_cnt`=WORDS_PER_BLK-1 with valid), also assert `fill_tag_we`=1 and `fill_done`=1, then go to DONE.
- DONE: all strobes 0, busy still 1. Go to COOL.
- COOL: busy 0, no new fill accepted. This gives the cache one cycle to re-evaluate hit with the new tag so a stale miss level is not re-served. Go to IDLE.
- Busy outputs: `i_fill_busy` = (state is FILL or DONE) and `fill_sel`=0. `d_fill_busy` is the same with `fill_sel`=1.
- Reset (any state, including mid-fill): return to IDLE and clear counters. In-flight memory returns arriving afterwards are ignored. Outputs reset to `mem_rd_en`=0, `mem_addr`=0, `fill_sel`=0, `fill_data`=0, `fill_word_we`=0, `fill_word_idx`=0, `fill_tag_we`=0, `fill_done`=0, both busy=0.
- Address 0xFFF0 block: issues 0xFFF0..0xFFFE with no wrap. Address arithmetic is 16-bit, and the carry out of the offset never reaches the tag bits.

## Timing
- Miss seen in IDLE at cycle t → FILL from t+1. `mem_rd_en` is high for cycles t+1..t+WORDS_PER_BLK, on consecutive cycles with no gaps.
- First `fill_word_we` at t+1+MEM_LAT. Last word, `fill_tag_we` and `fill_done` at t+WORDS_PER_BLK+MEM_LAT (t+12 at defaults).
- Busy high t+1..t+WORDS_PER_BLK+MEM_LAT+1. COOL is at t+WORDS_PER_BLK+MEM_LAT+2. A new fill can start from IDLE at t+WORDS_PER_BLK+MEM_LAT+3 at the earliest.
- `fill_*` outputs are combinational from `mem_data_valid`/`mem_data_in` and the registered `recv_cnt`. All other outputs are registered.
- Simultaneous `i_miss` and `d_miss` in IDLE: D is served first. I is served on the first IDLE cycle after COOL if it is still asserted.

## Configuration
- `FILL_PERF_CNT_EN` defined: adds output ports `i_fill_count` [15:0] and `d_fill_count` [15:0]. Each increments on `fill_done` for its side, saturates at 0xFFFF, and resets to 0.
- Not defined: those ports and counters are absent. All other behaviour is identical.

## Test plan
- Single I-miss at 0x0046, cycle 10 → `mem_addr` 0x0040..0x004E on cycles 11–18, `fill_word_idx` 0..7 on cycles 15–22, `fill_tag_we` and `fill_done` at cycle 22, `i_fill_busy` on cycles 11–23, `d_fill_busy`=0 throughout.
- `i_miss` 0x0100 and `d_miss` 0x2008 raised together → D fill of 0x2000 block first, then I fill of 0x0100 block starting 3 cycles after D `fill_done`.
- D-miss at 0xFFFC → addresses 0xFFF0..0xFFFE, no wrap to 0x0000.
- `rst_n` low for one cycle mid-FILL after 3 returned words → outputs at reset values next cycle; the 5 late `mem_data_valid` pulses produce no `fill_word_we`.
- `mem_data_valid` pulsed in IDLE with no miss → no `fill_word_we`, state stays IDLE.
- With `FILL_PERF_CNT_EN`: 3 D-fills and 2 I-fills → `d_fill_count`=3, `i_fill_count`=2.

Source files
------------

// File: rtl/cache_miss_fill_ctrl.sv
// cache_miss_fill_ctrl
//   Miss-fill controller between the I-cache, the D-cache and main memory.
//   On a miss it reads the whole block from memory and streams each returned
//   word into the requesting cache's data array. With the last word it writes
//   the tag. It also drives the per-side busy levels that stall the pipeline.
//   A D-miss wins over an I-miss that arrives in the same cycle.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   i_miss, i_miss_addr            I-cache miss level and byte address
//   d_miss, d_miss_addr            D-cache miss level and byte address
//   mem_rd_en, mem_addr            memory read strobe and byte address (registered)
//   mem_data_valid, mem_data_in    in-order memory return
//   fill_sel                       target cache, 0 = I, 1 = D (registered)
//   fill_data, fill_word_we,
//   fill_word_idx                  data-array write (combinational from return)
//   fill_tag_we, fill_done         tag write and completion pulse on last word
//   i_fill_busy, d_fill_busy       stall levels (registered)
//   i_fill_count, d_fill_count     saturating completed-fill counters, only
//                                  present when FILL_PERF_CNT_EN is defined
//
// Configuration macro: FILL_PERF_CNT_EN
//
// state | meaning
// IDLE  | waiting for a miss, D before I
// FILL  | issuing block reads and writing returned words
// DONE  | block written, busy still held
// COOL  | busy dropped, cache re-checks hit before another miss is taken
module cache_miss_fill_ctrl #(
  parameter int WORDS_PER_BLK = 8,
  parameter int MEM_LAT       = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_miss,
  input  logic [15:0]                      i_miss_addr,
  input  logic                             d_miss,
  input  logic [15:0]                      d_miss_addr,
  output logic                             mem_rd_en,
  output logic [15:0]                      mem_addr,
  input  logic                             mem_data_valid,
  input  logic [15:0]                      mem_data_in,
  output logic                             fill_sel,
  output logic [15:0]                      fill_data,
  output logic                             fill_word_we,
  output logic [$clog2(WORDS_PER_BLK)-1:0] fill_word_idx,
  output logic                             fill_tag_we,
  output logic                             fill_done,
  output logic                             i_fill_busy,
  output logic                             d_fill_busy
`ifdef FILL_PERF_CNT_EN
  ,
  output logic [15:0]                      i_fill_count,
  output logic [15:0]                      d_fill_count
`endif
);

  localparam int IDX_W   = $clog2(WORDS_PER_BLK);
  localparam int DRAIN_W = $clog2(MEM_LAT + 1);
  localparam logic [15:0]        OFS_MASK   = 16'(2 * WORDS_PER_BLK - 1);
  localparam logic [IDX_W:0]     ISSUE_END  = (IDX_W + 1)'(WORDS_PER_BLK);
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(WORDS_PER_BLK - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, FILL, DONE, COOL} stateT;

  stateT              state;
  logic [15:0]        baseAddr;
  logic [15:0]        missBase;
  logic [IDX_W:0]     issueCnt;
  logic [IDX_W-1:0]   recvCnt;
  logic [DRAIN_W-1:0] drainCnt;
  logic               wordAccept;
  logic               lastWord;

  // Reads issued just before a reset still come back up to MEM_LAT cycles
  // later. drainCnt masks exactly that window so those words can never land
  // in a fill that starts right after the reset; a new fill's first return
  // always arrives after the window has closed.
  assign wordAccept = rst_n && (state == FILL) && mem_data_valid && (drainCnt == '0);
  assign lastWord   = wordAccept && (recvCnt == LAST_IDX);

  assign fill_word_we  = wordAccept;
  assign fill_data     = wordAccept ? mem_data_in : '0;
  assign fill_word_idx = recvCnt;
  assign fill_tag_we   = lastWord;
  assign fill_done     = lastWord;

  assign missBase = (d_miss ? d_miss_addr : i_miss_addr) & ~OFS_MASK;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      baseAddr    <= '0;
      issueCnt    <= '0;
      recvCnt     <= '0;
      drainCnt    <= DRAIN_INIT;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      fill_sel    <= 1'b0;
      i_fill_busy <= 1'b0;
      d_fill_busy <= 1'b0;
    end else begin
      if (drainCnt != '0) drainCnt <= drainCnt - DRAIN_W'(1);
      case (state)
        IDLE: begin
          if (d_miss || i_miss) begin
            state       <= FILL;
            fill_sel    <= d_miss;
            baseAddr    <= missBase;
            mem_rd_en   <= 1'b1;
            mem_addr    <= missBase;
            issueCnt    <= (IDX_W + 1)'(1);
            recvCnt     <= '0;
            i_fill_busy <= !d_miss;
            d_fill_busy <= d_miss;
          end
        end
        FILL: begin
          // The offset add stays inside the block: the largest offset is
          // 2*(WORDS_PER_BLK-1) on a base whose offset bits are clear.
          if (issueCnt != ISSUE_END) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= baseAddr + 16'({issueCnt, 1'b0});
            issueCnt  <= issueCnt + (IDX_W + 1)'(1);
          end else begin
            mem_rd_en <= 1'b0;
          end
          if (wordAccept) recvCnt <= recvCnt + IDX_W'(1);
          if (lastWord) state <= DONE;
        end
        DONE: begin
          state       <= COOL;
          mem_rd_en   <= 1'b0;
          i_fill_busy <= 1'b0;
          d_fill_busy <= 1'b0;
        end
        COOL: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FILL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_fill_count <= '0;
      d_fill_count <= '0;
    end else if (fill_done) begin
      if (fill_sel) begin
        if (d_fill_count != 16'hFFFF) d_fill_count <= d_fill_count + 16'd1;
      end else begin
        if (i_fill_count != 16'hFFFF) i_fill_count <= i_fill_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_fill_ctrl.sv
// Bench for cache_miss_fill_ctrl: directed scenarios followed by random
// I/D misses. The reference model works in whole-fill terms: when a miss is
// accepted at cycle t it writes the expected per-cycle outputs of that fill
// into timeline arrays, and a negedge monitor compares the DUT against them.
module tb_cache_miss_fill_ctrl;

  localparam int W   = 8;
  localparam int LAT = 4;
  localparam int NC  = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_miss = 1'b0, d_miss = 1'b0;
  logic [15:0] i_miss_addr = '0, d_miss_addr = '0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data_in = '0;
  logic        mem_rd_en, fill_sel, fill_word_we, fill_tag_we, fill_done;
  logic        i_fill_busy, d_fill_busy;
  logic [15:0] mem_addr, fill_data;
  logic [2:0]  fill_word_idx;
`ifdef FILL_PERF_CNT_EN
  logic [15:0] i_fill_count, d_fill_count;
`endif

  cache_miss_fill_ctrl #(.WORDS_PER_BLK(W), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .fill_sel(fill_sel), .fill_data(fill_data), .fill_word_we(fill_word_we),
    .fill_word_idx(fill_word_idx), .fill_tag_we(fill_tag_we), .fill_done(fill_done),
    .i_fill_busy(i_fill_busy), .d_fill_busy(d_fill_busy)
`ifdef FILL_PERF_CNT_EN
    , .i_fill_count(i_fill_count), .d_fill_count(d_fill_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit monOn = 1'b0;

  // expected timeline
  bit          eRd[NC], eWe[NC], eDone[NC], eIB[NC], eDB[NC], eDoneSel[NC];
  logic [15:0] eAddr[NC], eData[NC];
  logic [2:0]  eIdx[NC];

  // memory model
  bit          rv[NC], xv[NC];
  logic [15:0] ra[NC];
  logic [15:0] salt;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return 16'(a * 16'h9E37) ^ salt;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, want);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, want);
    end
  endtask

  // A fill accepted at cycle t: reads t+1..t+W, words t+1+LAT.., done at
  // t+W+LAT, busy t+1..t+W+LAT+1.
  task automatic schedule(input int t, input bit s, input logic [15:0] a);
    logic [15:0] base;
    base = a & ~16'(2 * W - 1);
    for (int k = 0; k < W; k++) begin
      eRd[t + 1 + k]         = 1'b1;
      eAddr[t + 1 + k]       = base + 16'(2 * k);
      eWe[t + 1 + LAT + k]   = 1'b1;
      eIdx[t + 1 + LAT + k]  = 3'(k);
      eData[t + 1 + LAT + k] = memWord(base + 16'(2 * k));
    end
    eDone[t + W + LAT]    = 1'b1;
    eDoneSel[t + W + LAT] = s;
    for (int c = t + 1; c <= t + W + LAT + 1; c++) begin
      if (s) eDB[c] = 1'b1;
      else   eIB[c] = 1'b1;
    end
  endtask

  // Reset at cycle r: writes stop immediately, registered outputs from r+1.
  task automatic cancel(input int r);
    for (int c = r; c < NC; c++) begin
      eWe[c] = 1'b0;
      eDone[c] = 1'b0;
      if (c > r) begin
        eRd[c] = 1'b0;
        eIB[c] = 1'b0;
        eDB[c] = 1'b0;
      end
    end
  endtask

  // stimulus-side state
  bit          iReq = 1'b0, dReq = 1'b0;
  logic [15:0] iAddr = '0, dAddr = '0;
  int          curCycle = 0;
  int          freeAt = 0;
  int          dropAt = -1;
  bit          dropSide = 1'b0;
  int          lastRst = 0;

  task automatic tick(input bit rstVal);
    bit s;
    logic [15:0] a;
    @(posedge clk);
    #1;
    curCycle = cyc;
    if (curCycle == dropAt) begin
      if (dropSide) dReq = 1'b0;
      else          iReq = 1'b0;
    end
    rst_n = rstVal;
    i_miss = iReq;
    i_miss_addr = iAddr;
    d_miss = dReq;
    d_miss_addr = dAddr;
    if (!rstVal) begin
      cancel(curCycle);
      freeAt = curCycle + 1;
      dropAt = -1;
      lastRst = curCycle;
    end else if (curCycle >= freeAt && (dReq || iReq)) begin
      s = dReq;
      a = dReq ? dAddr : iAddr;
      schedule(curCycle, s, a);
      freeAt = curCycle + W + LAT + 3;
      dropAt = curCycle + W + LAT + 1;
      dropSide = s;
    end
  endtask

  task automatic runUntil(input int n);
    while (curCycle < n) tick(1'b1);
  endtask

  // memory: a read seen in cycle c returns in cycle c+LAT
  initial forever begin
    @(negedge clk);
    if (mem_rd_en === 1'b1 && cyc + LAT < NC) begin
      rv[cyc + LAT] = 1'b1;
      ra[cyc + LAT] = mem_addr;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (cyc < NC) begin
      mem_data_valid = rv[cyc] | xv[cyc];
      mem_data_in = rv[cyc] ? memWord(ra[cyc]) : 16'($urandom);
    end
  end

  initial forever begin
    @(negedge clk);
    if (monOn && cyc < NC) begin
      chk1("rd_en", mem_rd_en, eRd[cyc]);
      if (eRd[cyc]) chk16("mem_addr", mem_addr, eAddr[cyc]);
      chk1("word_we", fill_word_we, eWe[cyc]);
      if (eWe[cyc]) begin
        chk16("fill_data", fill_data, eData[cyc]);
        chk16("word_idx", 16'(fill_word_idx), 16'(eIdx[cyc]));
      end
      chk1("tag_we", fill_tag_we, eDone[cyc]);
      chk1("fill_done", fill_done, eDone[cyc]);
      chk1("i_busy", i_fill_busy, eIB[cyc]);
      chk1("d_busy", d_fill_busy, eDB[cyc]);
      if (eIB[cyc] || eDB[cyc]) chk1("fill_sel", fill_sel, eDB[cyc]);
    end
  end

  initial begin
    int expI, expD;
    salt = 16'($urandom);
    xv[6] = 1'b1;

    tick(1'b0);
    tick(1'b0);
    monOn = 1'b1;
    tick(1'b1);
    @(negedge clk);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk16("rst_word_idx", 16'(fill_word_idx), 16'h0000);
    chk1("rst_fill_sel", fill_sel, 1'b0);
    chk16("rst_fill_data", fill_data, 16'h0000);

    // stray return in IDLE
    runUntil(6);
    @(negedge clk);
    chk1("idle_stray_we", fill_word_we, 1'b0);

    // single I-miss at 0x0046, cycle 10
    runUntil(9);
    iReq = 1'b1; iAddr = 16'h0046;
    runUntil(11);
    @(negedge clk);
    chk16("i_first_addr", mem_addr, 16'h0040);
    runUntil(22);
    @(negedge clk);
    chk1("i_done_t22", fill_done, 1'b1);
    chk16("i_last_idx", 16'(fill_word_idx), 16'h0007);

    // simultaneous I and D at cycle 30: D first, I 3 cycles after D done
    runUntil(29);
    iReq = 1'b1; iAddr = 16'h0100;
    dReq = 1'b1; dAddr = 16'h2008;
    runUntil(31);
    @(negedge clk);
    chk16("d_first_addr", mem_addr, 16'h2000);
    chk1("d_sel", fill_sel, 1'b1);
    runUntil(44);
    @(negedge clk);
    chk1("cool_i_busy", i_fill_busy, 1'b0);
    chk1("cool_d_busy", d_fill_busy, 1'b0);
    runUntil(46);
    @(negedge clk);
    chk16("i_after_d_addr", mem_addr, 16'h0100);
    chk1("i_after_d_busy", i_fill_busy, 1'b1);

    // top-of-memory block, no wrap
    runUntil(64);
    dReq = 1'b1; dAddr = 16'hFFFC;
    runUntil(73);
    @(negedge clk);
    chk16("top_last_addr", mem_addr, 16'hFFFE);
    runUntil(74);
    @(negedge clk);
    chk1("top_rd_stop", mem_rd_en, 1'b0);

    // reset mid-fill after 3 returned words; D miss stays raised
    runUntil(84);
    dReq = 1'b1; dAddr = 16'h3456;
    runUntil(92);
    tick(1'b0);
    runUntil(94);
    @(negedge clk);
    chk16("midrst_mem_addr", mem_addr, 16'h0000);
    chk1("midrst_rd_en", mem_rd_en, 1'b0);
    chk1("midrst_busy", d_fill_busy, 1'b0);
    chk1("midrst_late_we", fill_word_we, 1'b0);

    // random I/D misses
    runUntil(115);
    for (int n = 0; n < 2000; n++) begin
      if (!iReq && $urandom_range(7) == 0) begin
        iReq = 1'b1; iAddr = 16'($urandom);
      end
      if (!dReq && $urandom_range(9) == 0) begin
        dReq = 1'b1; dAddr = 16'($urandom);
      end
      tick(1'b1);
    end
    while (iReq || dReq) tick(1'b1);
    runUntil(curCycle + 20);

`ifdef FILL_PERF_CNT_EN
    expI = 0;
    expD = 0;
    for (int c = lastRst; c < NC; c++) begin
      if (eDone[c]) begin
        if (eDoneSel[c]) expD++;
        else             expI++;
      end
    end
    @(negedge clk);
    chk16("i_fill_count", i_fill_count, 16'(expI));
    chk16("d_fill_count", d_fill_count, 16'(expD));
`else
    expI = 0;
    expD = 0;
`endif

    monOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
